// File: rtl/data_mem.sv
// data_mem: byte-addressed single-port data memory with a request/response handshake and wait states.
// Define DATA_MEM_FAULT_EN to enable size, misalignment and range fault reporting.
module data_mem #(
  parameter int unsigned WORDS       = 8192,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault
);
  localparam int unsigned IDX_W     = $clog2(WORDS);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t           state_r;
  logic             req_ready_r;
  logic             rsp_valid_r;
  logic             rsp_fault_r;
  logic [31:0]      rsp_rdata_r;
  logic [3:0]       cnt_r;
  logic             write_r;
  logic             unsigned_r;
  logic [31:0]      addr_r;
  logic [31:0]      wdata_r;
  logic [1:0]       size_r;
  logic [31:0]      mem_r [WORDS];

  logic             fault_s;
  logic             commit_s;
  logic [1:0]       size_s;
  logic [1:0]       lane_s;
  logic [IDX_W-1:0] idx_s;
  logic [3:0]       be_s;
  logic [31:0]      mask_s;
  logic [31:0]      wlane_s;
  logic [31:0]      rd_word_s;
  logic [7:0]       byte_s;
  logic [15:0]      half_s;
  logic [31:0]      load_s;
  logic [31:0]      merged_s;

`ifndef DATA_MEM_FAULT_EN
  // Upper index bits are deliberately ignored when the word index wraps.
  logic unused_s;
  assign unused_s = ^addr_r[31:IDX_W+2];
`endif

  // Decode the captured request: effective size/lane, fault, byte enables, load and store data
  always_comb begin
    size_s  = size_r;
    lane_s  = addr_r[1:0];
    fault_s = 1'b0;
    idx_s   = addr_r[IDX_W+1:2];
`ifdef DATA_MEM_FAULT_EN
    case (size_r)
      2'd0:    fault_s = 1'b0;
      2'd1:    fault_s = addr_r[0];
      2'd2:    fault_s = (addr_r[1:0] != 2'b00);
      default: fault_s = 1'b1;
    endcase
    fault_s = fault_s | ({2'b00, addr_r[31:2]} >= 32'(WORDS));
`else
    case (size_r)
      2'd0:    lane_s = addr_r[1:0];
      2'd1:    lane_s = {addr_r[1], 1'b0};
      default: begin
        size_s = 2'd2;
        lane_s = 2'b00;
      end
    endcase
`endif
    case (size_s)
      2'd0: begin
        be_s    = 4'b0001 << lane_s;
        wlane_s = {4{wdata_r[7:0]}};
      end
      2'd1: begin
        be_s    = lane_s[1] ? 4'b1100 : 4'b0011;
        wlane_s = {2{wdata_r[15:0]}};
      end
      default: begin
        be_s    = 4'b1111;
        wlane_s = wdata_r;
      end
    endcase
    mask_s    = {{8{be_s[3]}}, {8{be_s[2]}}, {8{be_s[1]}}, {8{be_s[0]}}};
    rd_word_s = mem_r[idx_s];
    byte_s    = rd_word_s[8*lane_s +: 8];
    half_s    = lane_s[1] ? rd_word_s[31:16] : rd_word_s[15:0];
    case (size_s)
      2'd0:    load_s = {{24{byte_s[7] & ~unsigned_r}}, byte_s};
      2'd1:    load_s = {{16{half_s[15] & ~unsigned_r}}, half_s};
      default: load_s = rd_word_s;
    endcase
    merged_s = (rd_word_s & ~mask_s) | (wlane_s & mask_s);
    // A reset on the commit edge must suppress the write.
    commit_s = (state_r == WAIT) && (cnt_r == 4'd0) && write_r && !fault_s && !rst;
  end

  // Control FSM, request capture and registered response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'd0;
      rsp_fault_r <= 1'b0;
      cnt_r       <= 4'd0;
      write_r     <= 1'b0;
      unsigned_r  <= 1'b0;
      addr_r      <= 32'd0;
      wdata_r     <= 32'd0;
      size_r      <= 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            write_r     <= req_write;
            unsigned_r  <= req_unsigned;
            addr_r      <= req_addr;
            wdata_r     <= req_wdata;
            size_r      <= req_size;
            cnt_r       <= WAIT_INIT;
            state_r     <= WAIT;
            req_ready_r <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            rsp_rdata_r <= (write_r || fault_s) ? 32'd0 : load_s;
            rsp_fault_r <= fault_s;
            rsp_valid_r <= 1'b1;
            state_r     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          req_ready_r <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  // Storage array; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (commit_s) begin
      mem_r[idx_s] <= merged_s;
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_fault = rsp_fault_r;

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: table-driven requests with a response scoreboard,
// plus hand-written stall and reset sequences. Expectations follow DATA_MEM_FAULT_EN.
module tb_data_mem;
  localparam int unsigned WORDS = 256;
  localparam int unsigned WS    = 3;
`ifdef DATA_MEM_FAULT_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] wd;
    logic [31:0] er;
    logic        ef;
  } vec_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        fault;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  data_mem #(.WORDS(WORDS), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with the block back in IDLE.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [1:0] sz, input logic u,
                        input logic [31:0] wd, input logic [31:0] er, input logic ef, input int stall);
    int   n;
    exp_t e;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_size = sz;
    req_unsigned = u; req_wdata = wd; rsp_ready = (stall == 0);
    @(posedge clk);
    sb.push_back('{er, ef});
    @(negedge clk);
    // Scramble the request bus: only the accept edge may matter.
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    req_size = 2'($urandom_range(0, 3)); req_unsigned = 1'($urandom_range(0, 1));
    req_write = 1'($urandom_range(0, 1));
    n = 1;
    while (!rsp_valid && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    if (!rsp_valid) begin
      check("rsp_timeout", 32'd0, 32'd1);
      void'(sb.pop_front());
      return;
    end
    check("latency", 32'(n), 32'(2 + WS));
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    for (int s = 0; s < stall; s++) begin
      check("stall_rdata", rsp_rdata, e.rdata);
      check("stall_fault", 32'(rsp_fault), 32'(e.fault));
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    check("rsp_rdata", rsp_rdata, e.rdata);
    check("rsp_fault", 32'(rsp_fault), 32'(e.fault));
    check("resp_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("handoff_valid", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] m100;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_size = 2'd0;
    req_unsigned = 1'b0; req_wdata = 32'd0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_fault", 32'(rsp_fault), 32'd0);

    m100 = FE ? 32'h80005A44 : 32'hBEEF5A44;
    //                 w     addr           sz    u     wdata          exp rdata                 exp fault
    vecs.push_back('{1'b1, 32'h0000_0100, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0,                    1'b0});
    vecs.push_back('{1'b0, 32'h0000_0100, 2'd2, 1'b0, 32'h0,       32'hDEADBEEF,              1'b0});
    vecs.push_back('{1'b1, 32'h0000_0100, 2'd2, 1'b0, 32'h11223344, 32'h0,                    1'b0});
    vecs.push_back('{1'b1, 32'h0000_0101, 2'd0, 1'b0, 32'hFFFFFF5A, 32'h0,                    1'b0});
    vecs.push_back('{1'b0, 32'h0000_0100, 2'd2, 1'b0, 32'h0,       32'h11225A44,              1'b0});
    vecs.push_back('{1'b0, 32'h0000_0101, 2'd0, 1'b0, 32'h0,       32'h0000005A,              1'b0});
    vecs.push_back('{1'b1, 32'h0000_0102, 2'd1, 1'b0, 32'h00008000, 32'h0,                    1'b0});
    vecs.push_back('{1'b0, 32'h0000_0102, 2'd1, 1'b0, 32'h0,       32'hFFFF8000,              1'b0});
    vecs.push_back('{1'b0, 32'h0000_0102, 2'd1, 1'b1, 32'h0,       32'h00008000,              1'b0});
    vecs.push_back('{1'b0, 32'h0000_0103, 2'd0, 1'b0, 32'h0,       32'hFFFFFF80,              1'b0});
    vecs.push_back('{1'b0, 32'h0000_0100, 2'd0, 1'b1, 32'h0,       32'h00000044,              1'b0});
    vecs.push_back('{1'b0, 32'h0000_0100, 2'd1, 1'b0, 32'h0,       32'h00005A44,              1'b0});
    vecs.push_back('{1'b1, 32'h0000_0103, 2'd1, 1'b0, 32'h0000BEEF, 32'h0,                    FE});
    vecs.push_back('{1'b0, 32'h0000_0102, 2'd2, 1'b0, 32'h0,       FE ? 32'h0 : m100,         FE});
    vecs.push_back('{1'b0, 32'h0000_0100, 2'd2, 1'b0, 32'h0,       m100,                      1'b0});
    vecs.push_back('{1'b0, 32'h0000_0100, 2'd3, 1'b0, 32'h0,       FE ? 32'h0 : m100,         FE});
    vecs.push_back('{1'b0, 32'h0000_0103, 2'd2, 1'b0, 32'h0,       FE ? 32'h0 : m100,         FE});
    vecs.push_back('{1'b1, 32'h0000_0000, 2'd2, 1'b0, 32'hCAFEF00D, 32'h0,                    1'b0});
    vecs.push_back('{1'b0, 32'h0000_0400, 2'd2, 1'b0, 32'h0,       FE ? 32'h0 : 32'hCAFEF00D, FE});
    vecs.push_back('{1'b1, 32'h0000_0004, 2'd2, 1'b0, 32'h12345678, 32'h0,                    1'b0});
    vecs.push_back('{1'b1, 32'h0000_0404, 2'd2, 1'b0, 32'h0BAD0BAD, 32'h0,                    FE});
    vecs.push_back('{1'b0, 32'h0000_0004, 2'd2, 1'b0, 32'h0,       FE ? 32'h12345678 : 32'h0BAD0BAD, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0200, 2'd2, 1'b0, 32'h00000000, 32'h0,                    1'b0});
    vecs.push_back('{1'b1, 32'h0000_0203, 2'd0, 1'b0, 32'h000000AB, 32'h0,                    1'b0});
    vecs.push_back('{1'b1, 32'h0000_0200, 2'd1, 1'b0, 32'h00001234, 32'h0,                    1'b0});
    vecs.push_back('{1'b0, 32'h0000_0200, 2'd2, 1'b0, 32'h0,       32'hAB001234,              1'b0});
    vecs.push_back('{1'b0, 32'h0000_0202, 2'd1, 1'b1, 32'h0,       32'h0000AB00,              1'b0});
    vecs.push_back('{1'b0, 32'h0000_0203, 2'd0, 1'b1, 32'h0,       32'h000000AB,              1'b0});
    vecs.push_back('{1'b1, 32'h0000_03FC, 2'd2, 1'b0, 32'h7F00FF01, 32'h0,                    1'b0});
    vecs.push_back('{1'b0, 32'h0000_03FC, 2'd0, 1'b0, 32'h0,       32'h00000001,              1'b0});
    vecs.push_back('{1'b0, 32'h0000_03FD, 2'd0, 1'b0, 32'h0,       32'hFFFFFFFF,              1'b0});
    vecs.push_back('{1'b0, 32'h0000_03FE, 2'd1, 1'b0, 32'h0,       32'h00007F00,              1'b0});

    foreach (vecs[i]) begin
      do_req(vecs[i].w, vecs[i].a, vecs[i].sz, vecs[i].u, vecs[i].wd, vecs[i].er, vecs[i].ef, 0);
    end

    // Consumer stalls for four cycles after the response appears.
    do_req(1'b0, 32'h0000_0200, 2'd2, 1'b0, 32'h0, 32'hAB001234, 1'b0, 4);

    // Reset one cycle into WAIT drops the store.
    do_req(1'b1, 32'h0000_0100, 2'd2, 1'b0, 32'h0F0F0F0F, 32'h0, 1'b0, 0);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0100; req_size = 2'd2;
    req_wdata = 32'h55555555; rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_wait_req_ready", 32'(req_ready), 32'd1);
    check("rst_wait_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_wait_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_wait_rsp_fault", 32'(rsp_fault), 32'd0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("rst_wait_no_ghost", 32'(rsp_valid), 32'd0);
    do_req(1'b0, 32'h0000_0100, 2'd2, 1'b0, 32'h0, 32'h0F0F0F0F, 1'b0, 0);

    // Reset on the commit edge itself: reset wins, no write.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0100; req_size = 2'd2;
    req_wdata = 32'hA5A5A5A5; rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (WS) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_commit_req_ready", 32'(req_ready), 32'd1);
    check("rst_commit_rsp_valid", 32'(rsp_valid), 32'd0);
    do_req(1'b0, 32'h0000_0100, 2'd2, 1'b0, 32'h0, 32'h0F0F0F0F, 1'b0, 0);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem.md
# data_mem

Parametrised single-port data memory for the `rv` core. It replaces the fixed word-indexed store with a byte-addressed request/response port and carries its own state machine. Features: configurable depth and wait states, byte/half/word stores on any legal lane, sign/zero-extended loads, and misalignment/range fault reporting. It sits between the control unit's load/store sequencing and the shared bus, and holds the core in its memory state until `rsp_valid`.

## Interface
- `WORDS`, 8192, depth in 32-bit words; power of two, 16..65536
- `WAIT_STATES`, 0, extra access cycles, 0..15
- `clk`  in  1  clock; one clock, all logic on posedge
- `rst`  in  1  reset; synchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  block can accept a request
- `req_write`  in  1  1 = store, 0 = load
- `req_addr`  in  32  byte address
- `req_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- `req_unsigned`  in  1  load zero-extends when 1, sign-extends when 0
- `req_wdata`  in  32  store data, right-justified
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  consumer takes response
- `rsp_rdata`  out  32  load result, extended; 0 for stores and faults
- `rsp_fault`  out  1  request faulted; memory untouched

## Operation
- States: IDLE, WAIT, RESP. `req_ready` = (state == IDLE). `rsp_valid` = (state == RESP).
- IDLE: on `req_valid && req_ready`:
  - capture the request into internal registers;
  - load the wait counter (4 bits) with `WAIT_STATES`;
  - go to WAIT.
- WAIT:
  - If the counter is nonzero, decrement it.
  - If the counter is 0, perform the access at this edge, register `rsp_rdata`/`rsp_fault`, and go to RESP.
- RESP: hold outputs stable until `rsp_ready`, then go to IDLE. No new request is accepted in the same cycle as the handoff.
- Word index = `addr[31:2]`; lane = `addr[1:0]`.
- Fault conditions (with `DATA_MEM_FAULT_EN`):
  - size 3;
  - half with `addr[0]` = 1;
  - word with `addr[1:0]` != 0;
  - `addr[31:2] >= WORDS`.
- A faulted request performs no read or write. It returns `rsp_fault` = 1 and `rsp_rdata` = 0.
- Store byte enables:
  - byte: lane `addr[1:0]` written with `wdata[7:0]`;
  - half: lanes {2·addr[1], 2·addr[1]+1} written with `wdata[15:0]`;
  - word: all four lanes written with `wdata`.
  - Unenabled lanes keep their prior contents.
- Load extraction:
  - byte: lane shifted to [7:0];
  - half: selected half shifted to [15:0];
  - word: unchanged.
  - Extension to 32 bits uses bit 7 (byte) or bit 15 (half) when `req_unsigned` = 0, and zeros otherwise.
- Memory contents are not reset.

## Timing
- Reset values:
  - state IDLE, so `req_ready` = 1 and `rsp_valid` = 0;
  - `rsp_rdata` = 0, `rsp_fault` = 0;
  - wait counter 0.
- Latency:
  - Request accepted in cycle A → `rsp_valid` first high in cycle A+2+`WAIT_STATES`.
  - With `rsp_ready` tied high: throughput is one request per 3+`WAIT_STATES` cycles, and the next accept comes at cycle A+3+`WAIT_STATES`.
- The store write commits at the WAIT→RESP edge only.
- `rsp_*` outputs must not change while `rsp_valid` && !`rsp_ready`.
- `req_*` inputs are sampled only on the accept edge; changes afterwards are ignored.
- `rst` asserted in any state returns the block to IDLE at that edge:
  - a store in WAIT that has not reached its commit edge is dropped;
  - a pending response is discarded.
- `rst` and commit on the same edge: reset wins, no write.
- Counter boundary: `WAIT_STATES` = 15 gives exactly 15 decrement cycles plus the access cycle; the counter never wraps.

## Configuration
- `DATA_MEM_FAULT_EN` defined:
  - misalignment, range and size-3 checks are active as described above.
- `DATA_MEM_FAULT_EN` undefined:
  - `rsp_fault` is tied to 0;
  - misaligned half/word accesses force the low address bits to 0 (half: `addr[0]`; word: `addr[1:0]`);
  - size 3 is treated as word;
  - the word index wraps modulo `WORDS` (upper index bits ignored).

## Test plan
- Reset, then word store 0xDEADBEEF at 0x100 followed by word load at 0x100, `WAIT_STATES` = 0, `rsp_ready` = 1 → `rsp_valid` in cycle A+2 for each request; load returns 0xDEADBEEF with fault 0.
- Byte store 0x5A at 0x101 over 0x11223344 → word reads 0x11225A44. Then a byte load at 0x101, signed, returns 0x0000005A. A half load at 0x102, signed, over 0x8000xxxx returns 0xFFFF8000; the same load unsigned returns 0x00008000.
- Half store at 0x103 and word load at 0x102 with fault enabled → `rsp_fault` = 1, `rsp_rdata` = 0, memory unchanged. Word load at byte address 4·`WORDS` → fault.
- `WAIT_STATES` = 3, `rsp_ready` held low for 4 cycles after `rsp_valid` → outputs stable throughout; `req_ready` = 0 until the cycle after `rsp_ready` is seen.
- Store issued, `rst` pulsed one cycle while in WAIT → no write (prior value reads back); block returns to IDLE with `req_ready` = 1 and `rsp_valid` = 0.
- Build without `DATA_MEM_FAULT_EN`: word load at 0x103 → returns the word at 0x100, fault 0.
